// File: rtl/sc_decode_pkg.sv
// Shared types and helpers for the stochastic-to-binary decode path.
package sc_decode_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } dec_state_t;

  // Window length in valid beats for a given bitstream resolution.
  function automatic int unsigned win_len(input int unsigned rwid);
    return 32'd1 << rwid;
  endfunction

  // Counter width: one extra bit so a full all-ones window (2^rwid) fits.
  function automatic int unsigned cnt_width(input int unsigned rwid);
    return rwid + 32'd1;
  endfunction

endpackage

// File: rtl/bitstream_lane_counter.sv
// Single-lane ones counter with synchronous clear and increment enable.
module bitstream_lane_counter
  import sc_decode_pkg::*;
#(
  parameter int RWID = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          en,
  input  logic                          bit_in,
  output logic [cnt_width(RWID)-1:0]    cnt
);

  localparam int CW = cnt_width(RWID);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + {{(CW-1){1'b0}}, bit_in};
    end
  end

endmodule

// File: rtl/bitstream_to_binary_array.sv
// Counts ones per lane over a 2^RWID valid-beat window and presents the counts
// with a valid/ready handshake.
module bitstream_to_binary_array
  import sc_decode_pkg::*;
#(
  parameter  int RWID  = 8,
  parameter  int BDIM  = 4,
  parameter  int SDIM  = 8,
  localparam int TDIM  = (BDIM < 1) ? 1 : BDIM,
  localparam int NLANE = TDIM * SDIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             inValid,
  input  logic [NLANE-1:0] inBit,
  input  logic             outReady,
  output logic             busy,
  output logic             outValid,
  output logic [RWID:0]    outCnt [NLANE],
  output logic [RWID:0]    beatCnt
);

  localparam logic [RWID:0] LAST_BEAT = (RWID+1)'(win_len(RWID) - 32'd1);

  dec_state_t state_q, state_d;
  logic       clr;
  logic       en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // start always wins over a coincident beat; in DONE it only acts with the handshake.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clr     = 1'b1;
          state_d = ACC;
        end
      end
      ACC: begin
        if (start) begin
          clr = 1'b1;
        end else if (inValid) begin
          en = 1'b1;
          if (beatCnt == LAST_BEAT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (outReady) begin
          if (start) begin
            clr     = 1'b1;
            state_d = ACC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == ACC);
  assign outValid = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      beatCnt <= '0;
    end else if (en) begin
      beatCnt <= beatCnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < TDIM; gi++) begin : g_group
    for (genvar gj = 0; gj < SDIM; gj++) begin : g_lane
      bitstream_lane_counter #(
        .RWID (RWID)
      ) u_lane (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (en),
        .bit_in (inBit[gi*SDIM+gj]),
        .cnt    (outCnt[gi*SDIM+gj])
      );
    end
  end

endmodule

// File: doc/bitstream_to_binary_array.md
Name: bitstream_to_binary_array

Overview:
- Decoder end of the shared-RNG unary path. It takes TDIM*SDIM parallel unipolar stochastic bitstreams and counts the 1s in each over a fixed window of 2^RWID valid beats.
- At the end of the window it presents one binary count per lane.
- It sits after the SC compute array and converts unary results back to binary for the host datapath and scoreboards.
- A simple FSM with a start pulse and a valid/ready output handshake frames each window.

Parameters:
- RWID, 8, rng/bitstream resolution; window length is 2^RWID valid beats.
- BDIM, 4, number of lane groups, matching the RNG buffer groups.
- TDIM, (BDIM<1)?1:BDIM, effective group count; covers the BDIM=0 corner case.
- SDIM, 8, lanes per group.
- NLANE, TDIM*SDIM, derived total lane count; not user-overridable.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, single-cycle pulse that clears the counters and opens a window.
- inValid, input, 1, inBit is a valid beat this cycle.
- inBit, input, NLANE, one stochastic bit per lane.
- outReady, input, 1, consumer accepts outCnt.
- busy, output, 1, high while in ACC.
- outValid, output, 1, high while in DONE.
- outCnt, output, array [NLANE] of RWID+1, per-lane count of 1s; range 0..2^RWID.
- beatCnt, output, RWID+1, valid beats accumulated in the current window.

Behaviour:
- All state updates on posedge clk. rst is synchronous, active-high and has priority over every other input.
- Reset values: state=IDLE, busy=0, outValid=0, beatCnt=0, every outCnt lane=0.
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - start=1 -> clear beatCnt and all outCnt, go to ACC next cycle.
  - Otherwise hold; inValid is ignored.
- ACC:
  - Each cycle with inValid=1: beatCnt+=1; each lane outCnt[k]+=inBit[k].
  - inValid=0 cycles are stalls: nothing changes.
  - When the beat making beatCnt==2^RWID is accepted, go to DONE next cycle. outValid is therefore high exactly 1 cycle after the last beat.
- Restart rule: start=1 in ACC clears counts and restarts the window, staying in ACC. The inValid beat in that same cycle is discarded; start wins.
- DONE:
  - outValid=1; outCnt and beatCnt held stable.
  - Input beats are ignored.
  - outValid&outReady -> go to IDLE, counts retained for observation.
  - If start=1 in the same cycle as the handshake -> go directly to ACC with counts cleared.
  - start without outReady is ignored; results are never lost.
- Arithmetic:
  - Counters are RWID+1 bits wide and unsigned. They cannot overflow because the window caps at 2^RWID beats.
  - Max value 2^RWID is reached only for an all-ones stream.
  - No saturation logic needed.
- Timing: no input pipelining; inputs are sampled in the cycle presented. Latency from the final beat to outValid is 1 cycle.
- Reset mid-window: rst in any state returns to IDLE with all counts zeroed on the next edge. The partial window is discarded.
- outReady high in IDLE/ACC is don't-care.

Decomposition:
- Shared package sc_decode_pkg holds:
  - FSM state enum dec_state_t (IDLE, ACC, DONE);
  - localparam helper for the window length (1<<RWID);
  - count type width RWID+1.
- One sub-module is natural: bitstream_lane_counter.
  - Function: one lane's RWID+1 counter with clear/inc-enable.
  - Structure: instantiated in a two-level generate (TDIM groups x SDIM lanes), lane index i*SDIM+j, matching the RNG sharing layout.
  - Control: the parent owns the FSM and beatCnt and drives common clr/en to all lanes.

Test Plan (RWID=3, BDIM=1, SDIM=2 unless noted; window=8 beats):
- Reset then idle 5 cycles with random inBit/inValid -> outValid=0, busy=0, all outCnt=0, beatCnt=0 throughout.
- start, then 8 consecutive valid beats: lane0 all 1s, lane1 pattern 10101010 -> outValid rises exactly 1 cycle after the 8th beat; outCnt[0]=8, outCnt[1]=4, beatCnt=8.
- Same stream with inValid=0 inserted every other cycle (16 cycles total) -> identical counts; outValid 1 cycle after the 8th valid beat.
- In DONE hold outReady=0 for 4 cycles while driving start and beats -> outCnt stable, state stays DONE. Then outReady=1 together with start=1 -> next cycle busy=1 with counts 0.
- start mid-window after 5 beats, then 8 more beats of lane0 all 1s -> outCnt[0]=8, not 13.
- rst asserted after 3 beats in ACC -> next cycle IDLE, counts 0, outValid stays 0. Repeat with BDIM=0 to confirm NLANE=SDIM lanes count correctly.
